// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - four-channel interval timer with prioritised, acknowledged interrupt
//
// Purpose:
//   Four programmable timer channels.
//   - Each channel counts up to its PERIOD and then sets its pending bit.
//   - In one-shot mode the channel also disables itself when it fires.
//   - A small interrupt FSM presents the lowest-index pending channel to
//     the CPU and waits for an ack.
//   - After each ack, irq is held low for a guaranteed gap.
//
// Ports:
//   clk     in   1      single clock, rising edge
//   reset   in   1      synchronous active-high reset
//   we      in   1      register write strobe
//   addr    in   3      register select
//   wdata   in   WIDTH  write data
//   rdata   out  WIDTH  combinational read of the register at addr
//   irq     out  1      interrupt request, registered, high only in ACTIVE
//   irq_id  out  2      channel being signalled, valid while irq=1
//   ack     in   1      CPU acknowledge of the current irq
//
// Register map:
//   0-3 PERIOD[n] (R/W)
//   4   EN[3:0]   (R/W)
//   5   MODE[3:0] (R/W, 1 = periodic)
//   6   PEND[3:0] (R, W1C)
//   7   {irq, irq_id, state} (RO)
//   Unused upper bits read as 0.
module timer_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  output logic [1:0]       irq_id,
  input  logic             ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_period [4];
  logic [WIDTH-1:0] r_cnt    [4];
  logic [3:0]       r_en;
  logic [3:0]       r_mode;
  logic [3:0]       r_pend;
  state_t           r_state;
  logic             r_irq;
  logic [1:0]       r_irq_id;

  logic [WIDTH-1:0] w_cnt_next [4];
  logic [3:0]       w_wr_period;
  logic             w_wr_en;
  logic             w_wr_mode;
  logic             w_wr_pend;
  logic [3:0]       w_en_rise;
  logic [3:0]       w_fire;
  logic [3:0]       w_en_next;
  logic [3:0]       w_ack_clr;
  logic [3:0]       w_sw_clr;
  logic [3:0]       w_pend_next;
  logic [1:0]       w_low_id;
  state_t           w_state_next;
  logic [1:0]       w_irq_id_next;

  // Register write decode.
  always_comb begin
    w_wr_en   = we && (addr == 3'd4);
    w_wr_mode = we && (addr == 3'd5);
    w_wr_pend = we && (addr == 3'd6);
    for (int n = 0; n < 4; n++) begin
      w_wr_period[n] = we && !addr[2] && (addr[1:0] == 2'(n));
    end
    // Only a 0->1 transition of EN restarts a channel's count.
    w_en_rise = w_wr_en ? (wdata[3:0] & ~r_en) : 4'b0000;
  end

  // Channel counters.
  // An event fires on the edge that follows cnt reaching PERIOD-1.
  // PERIOD=0 never fires, because the compare is gated by a nonzero
  // period. That gate also keeps PERIOD-1 from wrapping to all-ones.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_fire[n] = r_en[n] && (r_period[n] != '0) &&
                  (r_cnt[n] == r_period[n] - WIDTH'(1));
      w_cnt_next[n] = r_cnt[n];
      if (w_wr_period[n] || w_en_rise[n]) begin
        w_cnt_next[n] = '0;
      end else if (w_fire[n]) begin
        w_cnt_next[n] = '0;
      end else if (r_en[n] && (r_period[n] != '0)) begin
        w_cnt_next[n] = r_cnt[n] + WIDTH'(1);
      end
    end
  end

  // Enable and pending updates.
  // - A one-shot channel drops its own enable on the edge where it fires.
  // - Sets are ORed in after the clears, so an event beats a simultaneous
  //   ack or software clear on the same bit.
  always_comb begin
    w_en_next   = (w_wr_en ? wdata[3:0] : r_en) & ~(w_fire & ~r_mode);
    w_ack_clr   = (r_state == ST_ACTIVE && ack) ? (4'b0001 << r_irq_id) : 4'b0000;
    w_sw_clr    = w_wr_pend ? wdata[3:0] : 4'b0000;
    w_pend_next = (r_pend & ~(w_ack_clr | w_sw_clr)) | w_fire;
  end

  // Fixed priority: the lowest index wins.
  always_comb begin
    w_low_id = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (r_pend[n]) begin
        w_low_id = 2'(n);
      end
    end
  end

  // Interrupt FSM, next-state logic.
  // irq_id is latched only on entry to ACTIVE, so it stays stable even if
  // software clears the pending bit underneath it.
  always_comb begin
    w_state_next  = r_state;
    w_irq_id_next = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 4'b0000) begin
          w_state_next  = ST_ACTIVE;
          w_irq_id_next = w_low_id;
        end
      end
      ST_ACTIVE: begin
        if (ack) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        r_period[n] <= '0;
        r_cnt[n]    <= '0;
      end
      r_en     <= 4'b0000;
      r_mode   <= 4'b0000;
      r_pend   <= 4'b0000;
      r_state  <= ST_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= 2'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_wr_period[n]) begin
          r_period[n] <= wdata;
        end
        r_cnt[n] <= w_cnt_next[n];
      end
      if (w_wr_mode) begin
        r_mode <= wdata[3:0];
      end
      r_en     <= w_en_next;
      r_pend   <= w_pend_next;
      r_state  <= w_state_next;
      r_irq    <= (w_state_next == ST_ACTIVE);
      r_irq_id <= w_irq_id_next;
    end
  end

  // Register read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: rdata = r_period[addr[1:0]];
      3'd4:                   rdata = WIDTH'(r_en);
      3'd5:                   rdata = WIDTH'(r_mode);
      3'd6:                   rdata = WIDTH'(r_pend);
      3'd7:                   rdata = WIDTH'({r_irq, r_irq_id, r_state});
      default:                rdata = '0;
    endcase
  end

  assign irq    = r_irq;
  assign irq_id = r_irq_id;

endmodule
